wb_arbiter2: RTL

//  Two-master round-robin Wishbone arbiter. Shares the single 16-bit Wishbone slave bus
//  (unified program/data memory + I/O) between the J1 core (m0) and a second master (m1,
//  e.g. DMA/debug loader). Sits between the masters' if_wb ports and the memory/IO decoder.

---
 rtl/wb_arbiter2_pkg.sv | 15 +
 rtl/wb_arb_watchdog.sv | 36 +++
 rtl/wb_arbiter2.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter2_pkg.sv
// wb_arbiter2_pkg
//   Types and constants used by the two-master Wishbone arbiter.
//   arb_state_t : grant state (idle / master 0 / master 1)
//   NOOP        : J1 no-operation opcode returned on a watchdog-terminated read
package wb_arbiter2_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_t;

    localparam logic [15:0] NOOP = 16'h6000;

endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog
//   Counts stalled cycles of the granted transfer and flags expiry on the
//   TIMEOUT-th stalled cycle. Only instantiated when WB_ARB_TIMEOUT_EN is defined.
// Ports
//   clk       in   clock
//   reset_n   in   asynchronous active-low reset
//   stall_i   in   granted master strobing, slave not acking this cycle
//   clr_i     in   clear counter (ack seen, or no transfer in progress)
//   expire_o  out  high during the TIMEOUT-th consecutive stalled cycle
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic stall_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q;

    assign expire_o = stall_i & (cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr_i || expire_o) begin
            cnt_q <= '0;
        end else if (stall_i) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

endmodule

// File: rtl/wb_arbiter2.sv
// wb_arbiter2
//   Two-master round-robin Wishbone arbiter with a per-master burst quantum.
//   The grant is registered; the granted master is forwarded combinationally
//   to the shared slave bus. Optional watchdog: define WB_ARB_TIMEOUT_EN.
// Ports (m0/m1 seen from the arbiter, i.e. master outputs are _i here)
//   clk, reset_n                      clock, asynchronous active-low reset
//   mX_cyc_i/stb_i/we_i/adr_i/wdat_i  master X request (wdat = master dat_o)
//   mX_ack_o/rdat_o                   master X response (rdat = master dat_i)
//   s_cyc_o/stb_o/we_o/adr_o/wdat_o   shared slave bus request
//   s_ack_i/rdat_i                    shared slave bus response
//   gnt_o                             one-hot grant {m1,m0}, 00 = idle
module wb_arbiter2 #(
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16,
    parameter int unsigned QUANTUM = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_wdat_i,
    output logic          m0_ack_o,
    output logic [DW-1:0] m0_rdat_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_wdat_i,
    output logic          m1_ack_o,
    output logic [DW-1:0] m1_rdat_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_wdat_o,
    input  logic          s_ack_i,
    input  logic [DW-1:0] s_rdat_i,
    output logic [1:0]    gnt_o
);

    import wb_arbiter2_pkg::*;

    localparam int unsigned CW = $clog2(QUANTUM + 1);

    if (QUANTUM < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("wb_arbiter2: QUANTUM and TIMEOUT must be >= 1");
    end

    arb_state_t    state_q;
    logic [1:0]    gnt_q;
    logic          last_q;      // 1: m1 was granted most recently
    logic [CW-1:0] cnt_q;

    logic req0, req1, sel0, sel1;
    logic cur_cyc, cur_stb, cur_req, oth_req;
    logic expire, ack_eff;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;
    assign sel0 = (state_q == ARB_GNT0);
    assign sel1 = (state_q == ARB_GNT1);

    // Current/other views of the masters so the FSM handles both grants alike
    assign cur_cyc = sel0 ? m0_cyc_i : (sel1 ? m1_cyc_i : 1'b0);
    assign cur_stb = sel0 ? m0_stb_i : (sel1 ? m1_stb_i : 1'b0);
    assign cur_req = cur_cyc & cur_stb;
    assign oth_req = sel0 ? req1 : (sel1 ? req0 : 1'b0);

`ifdef WB_ARB_TIMEOUT_EN
    logic wd_stall, wd_clr;

    assign wd_stall = cur_req & ~s_ack_i;
    assign wd_clr   = s_ack_i | ~cur_req;

    wb_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .stall_i (wd_stall),
        .clr_i   (wd_clr),
        .expire_o(expire)
    );
`else
    assign expire = 1'b0;
`endif

    // A watchdog expiry terminates the transfer exactly like a slave ack
    assign ack_eff = s_ack_i | expire;

    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_wdat_o  = '0;
        m0_ack_o  = 1'b0;
        m0_rdat_o = '0;
        m1_ack_o  = 1'b0;
        m1_rdat_o = '0;
        if (sel0) begin
            s_cyc_o   = m0_cyc_i & ~expire;
            s_stb_o   = m0_stb_i & ~expire;
            s_we_o    = m0_we_i;
            s_adr_o   = m0_adr_i;
            s_wdat_o  = m0_wdat_i;
            m0_ack_o  = ack_eff;
            m0_rdat_o = expire ? DW'(NOOP) : s_rdat_i;
        end else if (sel1) begin
            s_cyc_o   = m1_cyc_i & ~expire;
            s_stb_o   = m1_stb_i & ~expire;
            s_we_o    = m1_we_i;
            s_adr_o   = m1_adr_i;
            s_wdat_o  = m1_wdat_i;
            m1_ack_o  = ack_eff;
            m1_rdat_o = expire ? DW'(NOOP) : s_rdat_i;
        end
    end

    assign gnt_o = gnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    cnt_q <= '0;
                    // Both requesting: m0 wins only if m1 was served last
                    if (req0 && (!req1 || last_q)) begin
                        state_q <= ARB_GNT0;
                        gnt_q   <= 2'b01;
                        last_q  <= 1'b0;
                    end else if (req1) begin
                        state_q <= ARB_GNT1;
                        gnt_q   <= 2'b10;
                        last_q  <= 1'b1;
                    end
                end
                ARB_GNT0, ARB_GNT1: begin
                    if (ack_eff) begin
                        if (oth_req && (cnt_q == CW'(QUANTUM - 1) || !cur_req)) begin
                            state_q <= sel0 ? ARB_GNT1 : ARB_GNT0;
                            gnt_q   <= sel0 ? 2'b10 : 2'b01;
                            last_q  <= sel0;
                            cnt_q   <= '0;
                        end else if (!cur_req) begin
                            state_q <= ARB_IDLE;
                            gnt_q   <= 2'b00;
                            cnt_q   <= '0;
                        end else if (cnt_q != CW'(QUANTUM - 1)) begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end else if (!cur_cyc || (!cur_stb && oth_req)) begin
                        // Bus cycle abandoned, or idle strobe while the other waits
                        cnt_q <= '0;
                        if (oth_req) begin
                            state_q <= sel0 ? ARB_GNT1 : ARB_GNT0;
                            gnt_q   <= sel0 ? 2'b10 : 2'b01;
                            last_q  <= sel0;
                        end else begin
                            state_q <= ARB_IDLE;
                            gnt_q   <= 2'b00;
                        end
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    gnt_q   <= 2'b00;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
